// File: rtl/lod_pkg.sv
// Shared constants, width helper and result record for the leading-one detector pipeline.
package lod_pkg;

    localparam int LOD_DEFAULT_WIDTH = 16;
    localparam int LOD_MAX_WIDTH     = 64;
    localparam int LOD_MAX_POS_W     = 6;

    function automatic int pos_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Sized for the widest legal operand; narrower instances use the low bits.
    typedef struct packed {
        logic [LOD_MAX_POS_W-1:0]   pos;
        logic                       zero;
        logic [LOD_MAX_WIDTH-2:0]   mant;
    } lod_result_t;

endpackage

// File: rtl/lod_core.sv
// Combinational leading-one detector: index of the most significant set bit plus an all-zero flag.
module lod_core
    import lod_pkg::*;
#(
    parameter int WIDTH = LOD_DEFAULT_WIDTH,
    parameter int POS_W = pos_width(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        pos  = '0;
        zero = 1'b1;
        // Ascending scan: the last set bit seen, i.e. the highest one, wins.
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                pos  = POS_W'(i);
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lod_pipe.sv
// Two-stage valid/ready leading-one pipeline: S1 = operand + position, S2 = position, zero flag, mantissa.
// Define LOD_PIPE_MANT_EN to build the S2 normaliser; otherwise out_mant is tied to zero.
module lod_pipe
    import lod_pkg::*;
#(
    parameter int WIDTH = LOD_DEFAULT_WIDTH,
    parameter int POS_W = pos_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_pos,
    output logic             out_zero,
    output logic [WIDTH-2:0] out_mant
);

    logic             r_s1_valid;
    logic [POS_W-1:0] r_s1_pos;
    logic             r_s1_zero;
    logic             r_s2_valid;
    logic [POS_W-1:0] r_s2_pos;
    logic             r_s2_zero;

    logic             w_s2_ready;
    logic             w_s1_adv;
    logic             w_in_fire;
    logic [POS_W-1:0] w_core_pos;
    logic             w_core_zero;

    lod_core #(
        .WIDTH (WIDTH),
        .POS_W (POS_W)
    ) u_core (
        .data (in_data),
        .pos  (w_core_pos),
        .zero (w_core_zero)
    );

    // No skid buffer: back-pressure ripples combinationally from out_ready to in_ready.
    assign w_s2_ready = !r_s2_valid || out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_ready;
    assign in_ready   = !r_s1_valid || w_s1_adv;
    assign w_in_fire  = in_valid && in_ready;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_pos   <= '0;
            r_s1_zero  <= 1'b0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_in_fire) begin
                r_s1_pos  <= w_core_pos;
                r_s1_zero <= w_core_zero;
            end
        end
    end

    // NOTE: payload registers are reset too, because outputs must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_pos   <= '0;
            r_s2_zero  <= 1'b0;
        end else begin
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
            end
            // Payload loads only on a real transfer, so outputs hold on empty cycles.
            if (w_s1_adv) begin
                r_s2_pos  <= r_s1_pos;
                r_s2_zero <= r_s1_zero;
            end
        end
    end

`ifdef LOD_PIPE_MANT_EN
    logic [WIDTH-2:0] r_s1_low;
    logic [POS_W-1:0] w_shamt;
    logic [WIDTH-2:0] w_norm;
    logic [WIDTH-2:0] r_s2_mant;

    // The leading one always shifts out of the fraction, so only the low bits are kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_low <= '0;
        end else if (w_in_fire) begin
            r_s1_low <= in_data[WIDTH-2:0];
        end
    end

    assign w_shamt = POS_W'(WIDTH - 1) - r_s1_pos;
    assign w_norm  = r_s1_low << w_shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_mant <= '0;
        end else if (w_s1_adv) begin
            r_s2_mant <= w_norm;
        end
    end

    assign out_mant = r_s2_mant;
`else
    assign out_mant = '0;
`endif

    assign out_valid = r_s2_valid;
    assign out_pos   = r_s2_pos;
    assign out_zero  = r_s2_zero;

endmodule

// File: tb/tb_lod_pipe.sv
// Bench for lod_pipe at WIDTH 8 and 16 sharing one handshake, checked against a queue-based reference.
module tb_lod_pipe;
    import lod_pkg::*;

`ifdef LOD_PIPE_MANT_EN
    localparam bit MANT_ON = 1'b1;
`else
    localparam bit MANT_ON = 1'b0;
`endif

    typedef struct {
        int          k;
        lod_result_t r;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  d8 = '0;
    logic [15:0] d16 = '0;

    logic        in_ready8, out_valid8, zero8;
    logic [2:0]  pos8;
    logic [6:0]  mant8;
    logic        in_ready16, out_valid16, zero16;
    logic [3:0]  pos16;
    logic [14:0] mant16;

    lod_pipe #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .in_data   (d8),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .out_pos   (pos8),
        .out_zero  (zero8),
        .out_mant  (mant8)
    );

    lod_pipe #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready16),
        .in_data   (d16),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .out_pos   (pos16),
        .out_zero  (zero16),
        .out_mant  (mant16)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          edges = 0;
    item_t       q8[$];
    item_t       q16[$];
    lod_result_t last8 = '0;
    lod_result_t last16 = '0;

    logic [7:0] tab_data [8] = '{8'h01, 8'h02, 8'h10, 8'h08, 8'h28, 8'h44, 8'hA0, 8'h00};
    int         tab_pos  [8] = '{0, 1, 4, 3, 5, 6, 7, 0};
    logic [6:0] tab_mant [8] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h08, 7'h20, 7'h00};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Position by repeated halving; fraction = operand minus its leading power of two, left-aligned.
    function automatic lod_result_t ref_model(input longint unsigned x, input int width);
        lod_result_t     r;
        longint unsigned t;
        int              p;
        r = '0;
        if (x == 0) begin
            r.zero = 1'b1;
            return r;
        end
        t = x;
        p = 0;
        while (t > 1) begin
            t = t >> 1;
            p++;
        end
        r.pos = 6'(p);
        if (MANT_ON) r.mant = 63'((x - (64'd1 << p)) << (width - 1 - p));
        return r;
    endfunction

    function automatic lod_result_t tab_result(input int i);
        lod_result_t r;
        r      = '0;
        r.pos  = 6'(tab_pos[i]);
        r.zero = (tab_data[i] == 8'h00);
        r.mant = MANT_ON ? 63'(tab_mant[i]) : '0;
        return r;
    endfunction

    task automatic check_outputs();
        bit exp_v;
        exp_v = (q8.size() > 0) && (edges >= q8[0].k + 1);
        check("out_valid8", out_valid8, exp_v);
        check("out_valid16", out_valid16, exp_v);
        if (exp_v) begin
            last8  = q8[0].r;
            last16 = q16[0].r;
        end
        check("out_pos8", 64'(pos8), 64'(last8.pos));
        check("out_zero8", zero8, last8.zero);
        check("out_mant8", 64'(mant8), 64'(last8.mant));
        check("out_pos16", 64'(pos16), 64'(last16.pos));
        check("out_zero16", zero16, last16.zero);
        check("out_mant16", 64'(mant16), 64'(last16.mant));
    endtask

    // Called at a falling edge; checks outputs, drives inputs, advances one clock.
    task automatic step(input bit iv, input logic [7:0] a8, input logic [15:0] a16,
                        input lod_result_t e8, input lod_result_t e16, input bit ordy,
                        output bit fired, output bit rdy_seen);
        bit exp_v, exp_rdy, ofire;
        exp_v = (q8.size() > 0) && (edges >= q8[0].k + 1);
        check_outputs();
        in_valid  = iv;
        d8        = a8;
        d16       = a16;
        out_ready = ordy;
        #1;
        exp_rdy  = (q8.size() < 2) || ordy;
        rdy_seen = in_ready8;
        check("in_ready8", in_ready8, exp_rdy);
        check("in_ready16", in_ready16, exp_rdy);
        fired = iv && exp_rdy;
        ofire = exp_v && ordy;
        @(posedge clk);
        edges++;
        if (ofire) begin
            void'(q8.pop_front());
            void'(q16.pop_front());
        end
        if (fired) begin
            q8.push_back('{k: edges, r: e8});
            q16.push_back('{k: edges, r: e16});
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bit f, r;
        for (int i = 0; i < 20 && q8.size() > 0; i++) begin
            step(1'b0, 8'h00, 16'h0000, '0, '0, 1'b1, f, r);
        end
        check("drain_empty", 64'(q8.size()), 64'd0);
        step(1'b0, 8'h00, 16'h0000, '0, '0, 1'b1, f, r);
    endtask

    // Feeds the directed table; out_ready is held low for stall_cycles at the start.
    task automatic run_table(input int stall_cycles, output int stall_accepts);
        bit f, r;
        int idx, tries;
        idx = 0;
        tries = 0;
        stall_accepts = 0;
        while (idx < 8 && tries < 60) begin
            step(1'b1, tab_data[idx], {8'h00, tab_data[idx]}, tab_result(idx),
                 ref_model(64'(tab_data[idx]), 16), (tries >= stall_cycles), f, r);
            if (tries < stall_cycles && r) stall_accepts++;
            if (f) idx++;
            tries++;
        end
        check("table_all_accepted", 64'(idx), 64'd8);
    endtask

    initial begin
        bit   f, r, hold, iv;
        int   acc;
        logic [7:0]  r8;
        logic [15:0] r16;

        @(negedge clk);
        check("rst_out_valid8", out_valid8, 1'b0);
        check("rst_out_valid16", out_valid16, 1'b0);
        check_outputs();
        rst_n = 1'b1;

        // Back-to-back stream including an all-zero operand.
        run_table(0, acc);
        drain();

        // Stall for five cycles under continuous offer: exactly two operands fit.
        run_table(5, acc);
        check("stall_accepts", 64'(acc), 64'd2);
        drain();

        // Fill both stages, then pulse reset between clock edges.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, tab_data[i + 4], {8'h00, tab_data[i + 4]}, tab_result(i + 4),
                 ref_model(64'(tab_data[i + 4]), 16), 1'b0, f, r);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid8", out_valid8, 1'b0);
        check("async_rst_valid16", out_valid16, 1'b0);
        check("async_rst_pos8", 64'(pos8), 64'd0);
        check("async_rst_mant8", 64'(mant8), 64'd0);
        check("async_rst_pos16", 64'(pos16), 64'd0);
        #1 rst_n = 1'b1;
        q8.delete();
        q16.delete();
        last8  = '0;
        last16 = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 16'h0000, '0, '0, 1'b1, f, r);
        end

        // Random traffic with random back-pressure; held operands stay stable until taken.
        hold = 1'b0;
        iv   = 1'b0;
        r8   = '0;
        r16  = '0;
        for (int i = 0; i < 800; i++) begin
            if (!hold) begin
                iv  = ($urandom_range(3) != 0);
                r8  = 8'($urandom);
                r16 = 16'($urandom);
                case ($urandom_range(7))
                    0: r8 = 8'h00;
                    1: r8 = 8'(1 << $urandom_range(7));
                    2: r16 = 16'h0000;
                    3: r16 = 16'(1 << $urandom_range(15));
                    default: ;
                endcase
            end
            step(iv, r8, r16, ref_model(64'(r8), 8), ref_model(64'(r16), 16),
                 ($urandom_range(9) < 7), f, r);
            hold = iv && !f;
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
